// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the dmem_pipe data memory
package dmem_pkg;

    // Load codes (req_load)
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b101;
    localparam logic [2:0] LD_LHU  = 3'b110;

    // Store codes (req_store)
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    // Fault codes (rsp_fault)
    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - combinational lane/fault decode for one memory access
// Ports:
//   load_i, store_i   access codes
//   addr_i            byte address (range check uses [31:2], lane uses [1:0])
//   wdata_i           right-justified store data
//   rword_i           current contents of the addressed word
//   be_o              byte write enables (zero on fault)
//   wdata_o           store data moved into its byte lanes
//   rdata_o           extracted and extended load data (zero on fault/store)
//   fault_o           fault code
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic [2:0]  load_i,
    input  logic [1:0]  store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  fault_o
);

    logic [1:0]  off;
    logic        illegal;
    logic        out_of_range;
    logic        misaligned;
    logic [31:0] rshift;

    assign off = addr_i[1:0];

    assign illegal = ((load_i != LD_NONE) && (store_i != ST_NONE)) ||
                     (load_i == 3'b100) || (load_i == 3'b111);

    assign out_of_range = {2'b00, addr_i[31:2]} >= 32'(DEPTH);

    // Halfwords may straddle the middle of a word but not its upper edge.
    assign misaligned = (((load_i == LD_LH) || (load_i == LD_LHU) || (store_i == ST_SH)) && (off == 2'b11)) ||
                        (((load_i == LD_LW) || (store_i == ST_SW)) && (off != 2'b00));

    always_comb begin
        fault_o = FAULT_OK;
        if (illegal)           fault_o = FAULT_ILL;
        else if (out_of_range) fault_o = FAULT_RANGE;
        else if (misaligned)   fault_o = FAULT_ALIGN;
    end

    assign wdata_o = wdata_i << {off, 3'b000};
    assign rshift  = rword_i >> {off, 3'b000};

    always_comb begin
        be_o = 4'b0000;
        if (fault_o == FAULT_OK) begin
            case (store_i)
                ST_SB:   be_o = 4'b0001 << off;
                ST_SH:   be_o = 4'b0011 << off;
                ST_SW:   be_o = 4'b1111;
                default: be_o = 4'b0000;
            endcase
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        if (fault_o == FAULT_OK) begin
            case (load_i)
                LD_LB:   rdata_o = {{24{rshift[7]}}, rshift[7:0]};
                LD_LH:   rdata_o = {{16{rshift[15]}}, rshift[15:0]};
                LD_LW:   rdata_o = rword_i;
                LD_LBU:  rdata_o = {24'h0, rshift[7:0]};
                LD_LHU:  rdata_o = {16'h0, rshift[15:0]};
                default: rdata_o = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - single-port word memory with byte/half/word access and 1-cycle response
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_addr, req_wdata              byte address, right-justified store data
//   req_load, req_store              access codes (see dmem_pkg)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_fault             extended load data, fault code
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load,
    input  logic [1:0]  req_store,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] init_cnt_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic [1:0]    rsp_fault_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] widx;
    logic          accept;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rsp_rdata_d;
    logic [1:0]    rsp_fault_d;

    assign widx = req_addr[AW+1:2];

    // Gating with rst keeps a request presented during reset from being taken.
    assign req_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    dmem_align #(.DEPTH(DEPTH)) u_align (
        .load_i  (req_load),
        .store_i (req_store),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .rword_i (mem[widx]),
        .be_o    (be),
        .wdata_o (wdata_sh),
        .rdata_o (rsp_rdata_d),
        .fault_o (rsp_fault_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_CLEAR ? S_INIT : S_IDLE;
            init_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= FAULT_OK;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == CNT_LAST) state_q <= S_IDLE;
                end
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_fault_q <= rsp_fault_d;
                    end else if ((state_q == S_RESP) && rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; it is cleared by the INIT sweep instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem[init_cnt_q] <= 32'h0;
            end else if (accept) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb/tb_dmem_pipe.sv - scoreboard bench for dmem_pipe with DEPTH=8
module tb_dmem_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_load = 3'b000;
    logic [1:0]  req_store = 2'b00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    always #5 clk = ~clk;

    dmem_pipe #(.DEPTH(8), .INIT_CLEAR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_load  (req_load),
        .req_store (req_store),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the edge after a negedge where valid&ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid === 1'b1 && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h with empty scoreboard", rsp_rdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, " rdata"}, rsp_rdata, mon_e.rdata);
                    chk({mon_e.name, " fault"}, {30'h0, rsp_fault}, {30'h0, mon_e.fault});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] ld, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic [1:0] ef);
        exp_t e;
        bit   ok;
        e.name = name;
        e.rdata = er;
        e.fault = ef;
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_addr  = a;
        req_wdata = wd;
        sb.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s accept_timeout: req_ready stayed 0, expected 1", name);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_load  = 3'b000;
        req_store = 2'b00;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s drain_timeout: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset(input string name);
        int n;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 2'b00;
        @(negedge clk);
        chk({name, " rst rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({name, " rst req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({name, " rst rsp_rdata"}, rsp_rdata, 32'h0);
        chk({name, " rst rsp_fault"}, {30'h0, rsp_fault}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        chk({name, " init_len"}, 32'(n), 32'd8);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("por");

        issue("lw_1c_cleared", 3'b011, 2'b00, 32'h1C, 32'h0, 32'h0000_0000, 2'b00);

        issue("sw_4",     3'b000, 2'b11, 32'h4, 32'h1122_3344, 32'h0, 2'b00);
        issue("sb_6",     3'b000, 2'b01, 32'h6, 32'h0000_00AA, 32'h0, 2'b00);
        issue("lw_4",     3'b011, 2'b00, 32'h4, 32'h0, 32'h11AA_3344, 2'b00);
        issue("lbu_6",    3'b101, 2'b00, 32'h6, 32'h0, 32'h0000_00AA, 2'b00);
        issue("lb_6",     3'b001, 2'b00, 32'h6, 32'h0, 32'hFFFF_FFAA, 2'b00);

        issue("sh_9",     3'b000, 2'b10, 32'h9, 32'h0000_8001, 32'h0, 2'b00);
        issue("lh_9",     3'b010, 2'b00, 32'h9, 32'h0, 32'hFFFF_8001, 2'b00);
        issue("lhu_9",    3'b110, 2'b00, 32'h9, 32'h0, 32'h0000_8001, 2'b00);
        issue("lw_8",     3'b011, 2'b00, 32'h8, 32'h0, 32'h0080_0100, 2'b00);
        issue("lh_b",     3'b010, 2'b00, 32'hB, 32'h0, 32'h0, 2'b01);
        issue("sw_2_mis", 3'b000, 2'b11, 32'h2, 32'hDEAD_BEEF, 32'h0, 2'b01);
        issue("lw_0_a",   3'b011, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00);

        issue("lw_20_oor",  3'b011, 2'b00, 32'h20, 32'h0, 32'h0, 2'b10);
        issue("ld_st_ill",  3'b011, 2'b11, 32'h0, 32'h5555_5555, 32'h0, 2'b11);
        issue("ld100_ill",  3'b100, 2'b00, 32'h4, 32'h0, 32'h0, 2'b11);
        issue("lw_0_b",     3'b011, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00);
        issue("noop_4",     3'b000, 2'b00, 32'h4, 32'h0, 32'h0, 2'b00);
        drain("basic");

        issue("b2b_sw", 3'b000, 2'b11, 32'h10, 32'hCAFE_F00D, 32'h0, 2'b00);
        issue("b2b_lw", 3'b011, 2'b00, 32'h10, 32'h0, 32'hCAFE_F00D, 2'b00);
        drain("b2b");
        if (pop_cyc.size() >= 2)
            chk("b2b spacing", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 32'd1);
        else
            chk("b2b pops", 32'(pop_cyc.size()), 32'd2);

        rsp_ready = 1'b0;
        issue("stall_lw_4", 3'b011, 2'b00, 32'h4, 32'h0, 32'h11AA_3344, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("stall req_ready", {31'h0, req_ready}, 32'h0);
            chk("stall rsp_rdata", rsp_rdata, 32'h11AA_3344);
            chk("stall rsp_fault", {30'h0, rsp_fault}, 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain("stall");

        rsp_ready = 1'b0;
        issue("rst_pending", 3'b011, 2'b00, 32'h4, 32'h0, 32'h11AA_3344, 2'b00);
        req_valid = 1'b1;
        req_store = 2'b11;
        req_addr  = 32'hC;
        req_wdata = 32'hFFFF_FFFF;
        do_reset("mid");
        rsp_ready = 1'b1;
        issue("lw_4_after_rst", 3'b011, 2'b00, 32'h4, 32'h0, 32'h0, 2'b00);
        issue("lw_c_after_rst", 3'b011, 2'b00, 32'hC, 32'h0, 32'h0, 2'b00);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
